// File: rtl/palette_bank_ctrl_if.sv
// Palette controller bus: palette write port, bank-swap control and pixel lookup/result.
// Pure wiring, no latency; write back-pressure is carried by wr_ready, lookups have none.
// Ports: master = palette writer / pixel source side, slave = palette_bank_ctrl.
interface palette_bank_ctrl_if #(
  parameter int INDEX_W = 4,
  parameter int CH_W    = 4
);
  // palette write request, handshaked
  logic               wr_valid;
  logic               wr_ready;
  logic [INDEX_W-1:0] wr_index;
  logic [3*CH_W-1:0]  wr_rgb;
  // bank swap control and status
  logic               swap_req;
  logic               vsync;
  logic               swap_done;
  logic               active_bank;
  // pixel lookup request and faded result
  logic               pix_valid;
  logic [INDEX_W-1:0] pix_index;
  logic [CH_W-1:0]    fade_level;
  logic               out_valid;
  logic               out_transparent;
  logic [CH_W-1:0]    red;
  logic [CH_W-1:0]    green;
  logic [CH_W-1:0]    blue;

  modport master (
    output wr_valid, wr_index, wr_rgb, swap_req, vsync, pix_valid, pix_index, fade_level,
    input  wr_ready, swap_done, active_bank, out_valid, out_transparent, red, green, blue
  );

  modport slave (
    input  wr_valid, wr_index, wr_rgb, swap_req, vsync, pix_valid, pix_index, fade_level,
    output wr_ready, swap_done, active_bank, out_valid, out_transparent, red, green, blue
  );
endinterface

// File: rtl/palette_bank_ctrl.sv
// Double-buffered colour palette: writes go to the shadow bank, lookups read the active bank, swap on vsync.
// Lookup latency 2 cycles, 1 per cycle; swap_done 1 cycle after the vsync that performs the swap.
// Backpressure: wr_ready drops only in the swap cycle (source holds the write); lookups are never stalled.
// Ports: Clk, Reset (async, active-high); bus (slave modport): wr_* write port, swap_req/vsync/swap_done/
//        active_bank swap control, pix_*/fade_level lookup in, out_valid/out_transparent/red/green/blue out.
module palette_bank_ctrl #(
  parameter int INDEX_W    = 4,
  parameter int CH_W       = 4,
  parameter int TRANSP_IDX = 0
) (
  input  logic                 Clk,
  input  logic                 Reset,
  palette_bank_ctrl_if.slave   bus
);
  localparam int DEPTH  = 1 << INDEX_W;
  localparam int RGB_W  = 3 * CH_W;
  localparam int PROD_W = 2 * CH_W + 1;

  typedef enum logic {
    SWAP_IDLE,
    SWAP_ARMED
  } swap_state_t;

  swap_state_t state, state_nxt;
  logic        swap_fire;
  logic        wr_fire;

  logic [1:0][DEPTH-1:0][RGB_W-1:0] banks;
  logic                             active;
  logic                             done_q;

  logic             s1_vld;
  logic             s1_transp;
  logic [RGB_W-1:0] s1_rgb;
  logic [CH_W-1:0]  s1_fade;

  logic             out_vld;
  logic             out_transp;
  logic [CH_W-1:0]  red_q;
  logic [CH_W-1:0]  green_q;
  logic [CH_W-1:0]  blue_q;

  // (ch * (lvl+1)) >> CH_W: lvl all-ones gives ch*2^CH_W >> CH_W = ch exactly.
  function automatic logic [CH_W-1:0] scale(input logic [CH_W-1:0] ch, input logic [CH_W-1:0] lvl);
    logic [PROD_W-1:0] prod;
    prod = PROD_W'(ch) * (PROD_W'(lvl) + PROD_W'(1));
    return CH_W'(prod >> CH_W);
  endfunction

  // Swap arming: extra swap_req while armed is absorbed; a swap_req arriving
  // with vsync in the idle state only arms, the swap waits for the next vsync.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= SWAP_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    swap_fire = 1'b0;
    case (state)
      SWAP_IDLE:  if (bus.swap_req) state_nxt = SWAP_ARMED;
      SWAP_ARMED: if (bus.vsync) begin
        swap_fire = 1'b1;
        state_nxt = SWAP_IDLE;
      end
      default:    state_nxt = SWAP_IDLE;
    endcase
  end

  // Writes are held off in the swap cycle so they always land in the bank
  // that is shadow after the edge, never in the bank becoming active.
  assign bus.wr_ready = ~Reset & ~swap_fire;
  assign wr_fire      = bus.wr_valid & bus.wr_ready;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      banks  <= '0;
      active <= 1'b0;
      done_q <= 1'b0;
    end else begin
      if (wr_fire) banks[~active][bus.wr_index] <= bus.wr_rgb;
      if (swap_fire) active <= ~active;
      done_q <= swap_fire;
    end
  end

  // Stage 1 samples the bank active at this edge (pre-swap in the swap cycle);
  // stage 2 applies the fade. Data registers only load on valid so the
  // outputs hold their last result between lookups.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      s1_vld     <= 1'b0;
      s1_transp  <= 1'b0;
      s1_rgb     <= '0;
      s1_fade    <= '0;
      out_vld    <= 1'b0;
      out_transp <= 1'b0;
      red_q      <= '0;
      green_q    <= '0;
      blue_q     <= '0;
    end else begin
      s1_vld <= bus.pix_valid;
      if (bus.pix_valid) begin
        s1_rgb    <= banks[active][bus.pix_index];
        s1_transp <= (bus.pix_index == INDEX_W'(TRANSP_IDX));
        s1_fade   <= bus.fade_level;
      end
      out_vld <= s1_vld;
      if (s1_vld) begin
        out_transp <= s1_transp;
        red_q      <= scale(s1_rgb[RGB_W-1 -: CH_W], s1_fade);
        green_q    <= scale(s1_rgb[2*CH_W-1 -: CH_W], s1_fade);
        blue_q     <= scale(s1_rgb[CH_W-1:0], s1_fade);
      end
    end
  end

  assign bus.swap_done       = done_q;
  assign bus.active_bank     = active;
  assign bus.out_valid       = out_vld;
  assign bus.out_transparent = out_transp;
  assign bus.red             = red_q;
  assign bus.green           = green_q;
  assign bus.blue            = blue_q;
endmodule

// File: tb/tb_palette_bank_ctrl.sv
// Testbench for palette_bank_ctrl: directed scenarios plus randomized traffic
// compared against a bank/queue reference model of the palette behaviour.
module tb_palette_bank_ctrl;
  localparam int IW = 4;
  localparam int CW = 4;
  localparam int TI = 0;
  localparam int OW = 3 * CW + 2;

  logic Clk   = 1'b0;
  logic Reset = 1'b0;
  always #5 Clk = ~Clk;

  palette_bank_ctrl_if #(.INDEX_W(IW), .CH_W(CW)) bus ();

  palette_bank_ctrl #(.INDEX_W(IW), .CH_W(CW), .TRANSP_IDX(TI)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: two palettes, active bank number, pending flag, and a
  // queue of expected results tagged with the cycle they must appear in.
  typedef struct {
    int              due;
    logic            t;
    logic [CW-1:0]   r;
    logic [CW-1:0]   g;
    logic [CW-1:0]   b;
  } exp_t;

  logic [3*CW-1:0] m_bank [2][1<<IW];
  int              m_active;
  bit              m_pending;
  bit              m_done;
  exp_t            q[$];
  logic [OW-1:0]   e_out;
  int              cyc = 0;

  function automatic int fade(int ch, int f);
    return (ch * (f + 1)) / (1 << CW);
  endfunction

  function automatic logic [OW-1:0] obs();
    return {bus.out_valid, bus.out_transparent, bus.red, bus.green, bus.blue};
  endfunction

  task automatic idle();
    bus.wr_valid   = 1'b0;
    bus.wr_index   = '0;
    bus.wr_rgb     = '0;
    bus.swap_req   = 1'b0;
    bus.vsync      = 1'b0;
    bus.pix_valid  = 1'b0;
    bus.pix_index  = '0;
    bus.fade_level = '0;
  endtask

  task automatic m_reset();
    foreach (m_bank[b, i]) m_bank[b][i] = '0;
    m_active  = 0;
    m_pending = 1'b0;
    m_done    = 1'b0;
    q.delete();
    e_out = '0;
  endtask

  // Apply the current inputs to the model, then advance one clock.
  task automatic cycle();
    bit              fire;
    exp_t            e;
    logic [3*CW-1:0] ent;
    fire = 1'b0;
    if (!Reset) begin
      fire = bus.vsync && m_pending;
      if (bus.wr_valid && !fire) m_bank[1-m_active][bus.wr_index] = bus.wr_rgb;
      if (bus.pix_valid) begin
        ent   = m_bank[m_active][bus.pix_index];
        e.due = cyc + 2;
        e.t   = (int'(bus.pix_index) == TI);
        e.r   = CW'(fade(int'(ent[3*CW-1:2*CW]), int'(bus.fade_level)));
        e.g   = CW'(fade(int'(ent[2*CW-1:CW]), int'(bus.fade_level)));
        e.b   = CW'(fade(int'(ent[CW-1:0]), int'(bus.fade_level)));
        q.push_back(e);
      end
      if (fire) begin
        m_active  = 1 - m_active;
        m_pending = 1'b0;
      end else if (bus.swap_req) begin
        m_pending = 1'b1;
      end
    end
    m_done = fire;
    @(posedge Clk);
    #1;
    cyc++;
    e_out[OW-1] = 1'b0;
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      e_out = {1'b1, e.t, e.r, e.g, e.b};
    end
  endtask

  task automatic test_reset();
    idle();
    #2;
    bus.wr_valid = 1'b1;
    Reset = 1'b1;
    m_reset();
    #1;
    tests_run++;
    if (obs() !== '0) begin tests_failed++; $display("FAIL reset_outputs: got %h want 0", obs()); end
    tests_run++;
    if ({bus.active_bank, bus.swap_done} !== 2'b00) begin
      tests_failed++; $display("FAIL reset_bank_done: got %b want 00", {bus.active_bank, bus.swap_done});
    end
    tests_run++;
    if (bus.wr_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_wr_ready: got %b want 0", bus.wr_ready); end
    cycle();
    cycle();
    Reset = 1'b0;
    idle();
    #1;
    tests_run++;
    if (bus.wr_ready !== 1'b1) begin tests_failed++; $display("FAIL release_wr_ready: got %b want 1", bus.wr_ready); end
  endtask

  task automatic test_lookup_pre_swap();
    idle();
    bus.wr_valid = 1'b1; bus.wr_index = 4'd3; bus.wr_rgb = 12'hA86;
    bus.pix_valid = 1'b1; bus.pix_index = 4'd3; bus.fade_level = 4'hF;
    cycle();
    idle();
    bus.pix_valid = 1'b1; bus.pix_index = 4'd0; bus.fade_level = 4'hF;
    cycle();
    tests_run++;
    if (obs() !== 14'h2000) begin tests_failed++; $display("FAIL pre_swap_idx3: got %h want 2000", obs()); end
    idle();
    cycle();
    tests_run++;
    if ({bus.out_valid, bus.out_transparent} !== 2'b11) begin
      tests_failed++; $display("FAIL transparent_idx0: got %b want 11", {bus.out_valid, bus.out_transparent});
    end
    cycle();
    tests_run++;
    if (obs() !== 14'h1000) begin tests_failed++; $display("FAIL hold_when_invalid: got %h want 1000", obs()); end
  endtask

  task automatic test_swap();
    idle();
    bus.swap_req = 1'b1;
    cycle();
    tests_run++;
    if ({bus.active_bank, bus.swap_done} !== 2'b00) begin
      tests_failed++; $display("FAIL arm_only: got %b want 00", {bus.active_bank, bus.swap_done});
    end
    idle();
    bus.vsync = 1'b1;
    bus.pix_valid = 1'b1; bus.pix_index = 4'd3; bus.fade_level = 4'hF;
    #1;
    tests_run++;
    if (bus.wr_ready !== 1'b0) begin tests_failed++; $display("FAIL swap_cycle_wr_ready: got %b want 0", bus.wr_ready); end
    cycle();
    tests_run++;
    if ({bus.active_bank, bus.swap_done} !== 2'b11) begin
      tests_failed++; $display("FAIL swap_done_pulse: got %b want 11", {bus.active_bank, bus.swap_done});
    end
    idle();
    bus.pix_valid = 1'b1; bus.pix_index = 4'd3; bus.fade_level = 4'hF;
    cycle();
    tests_run++;
    if (bus.swap_done !== 1'b0) begin tests_failed++; $display("FAIL swap_done_width: got %b want 0", bus.swap_done); end
    tests_run++;
    if (obs() !== 14'h2000) begin tests_failed++; $display("FAIL lookup_in_swap_cycle: got %h want 2000", obs()); end
    idle();
    cycle();
    tests_run++;
    if (obs() !== 14'h2A86) begin tests_failed++; $display("FAIL post_swap_idx3: got %h want 2a86", obs()); end
  endtask

  task automatic test_fade();
    idle();
    bus.wr_valid = 1'b1; bus.wr_index = 4'd5; bus.wr_rgb = 12'hF81; bus.swap_req = 1'b1;
    cycle();
    idle();
    bus.vsync = 1'b1;
    cycle();
    idle();
    bus.pix_valid = 1'b1; bus.pix_index = 4'd5; bus.fade_level = 4'd7;
    cycle();
    bus.fade_level = 4'd0;
    cycle();
    tests_run++;
    if (obs() !== 14'h2740) begin tests_failed++; $display("FAIL fade_7: got %h want 2740", obs()); end
    idle();
    cycle();
    tests_run++;
    if (obs() !== 14'h2000) begin tests_failed++; $display("FAIL fade_0: got %h want 2000", obs()); end
  endtask

  task automatic test_write_stall();
    idle();
    bus.swap_req = 1'b1;
    cycle();
    idle();
    bus.vsync = 1'b1;
    bus.wr_valid = 1'b1; bus.wr_index = 4'd9; bus.wr_rgb = 12'h123;
    #1;
    tests_run++;
    if (bus.wr_ready !== 1'b0) begin tests_failed++; $display("FAIL stall_wr_ready: got %b want 0", bus.wr_ready); end
    cycle();
    bus.vsync = 1'b0;
    #1;
    tests_run++;
    if (bus.wr_ready !== 1'b1) begin tests_failed++; $display("FAIL retry_wr_ready: got %b want 1", bus.wr_ready); end
    cycle();
    idle();
    bus.pix_valid = 1'b1; bus.pix_index = 4'd9; bus.fade_level = 4'hF;
    cycle();
    idle();
    bus.swap_req = 1'b1;
    cycle();
    tests_run++;
    if (obs() !== 14'h2000) begin tests_failed++; $display("FAIL stalled_write_not_active: got %h want 2000", obs()); end
    idle();
    bus.vsync = 1'b1;
    cycle();
    idle();
    bus.pix_valid = 1'b1; bus.pix_index = 4'd9; bus.fade_level = 4'hF;
    cycle();
    idle();
    cycle();
    tests_run++;
    if (obs() !== 14'h2123) begin tests_failed++; $display("FAIL stalled_write_landed: got %h want 2123", obs()); end
  endtask

  task automatic test_double_swap();
    bit sreq [7] = '{1, 1, 0, 0, 0, 0, 0};
    bit vs   [7] = '{0, 0, 1, 0, 1, 0, 0};
    int done_cnt = 0;
    logic start_bank;
    start_bank = bus.active_bank;
    for (int i = 0; i < 7; i++) begin
      idle();
      bus.swap_req = sreq[i];
      bus.vsync    = vs[i];
      cycle();
      if (bus.swap_done === 1'b1) done_cnt++;
    end
    tests_run++;
    if (done_cnt !== 1) begin tests_failed++; $display("FAIL double_swap_done_count: got %0d want 1", done_cnt); end
    tests_run++;
    if (bus.active_bank !== ~start_bank) begin
      tests_failed++; $display("FAIL double_swap_bank: got %b want %b", bus.active_bank, ~start_bank);
    end
  endtask

  task automatic test_random();
    logic exp_rdy;
    for (int n = 0; n < 600; n++) begin
      bus.wr_valid   = 1'($urandom_range(0, 1));
      bus.wr_index   = IW'($urandom);
      bus.wr_rgb     = 12'($urandom);
      bus.swap_req   = ($urandom_range(0, 7) == 0);
      bus.vsync      = ($urandom_range(0, 5) == 0);
      bus.pix_valid  = ($urandom_range(0, 3) != 0);
      bus.pix_index  = IW'($urandom);
      bus.fade_level = CW'($urandom);
      #1;
      exp_rdy = !(bus.vsync && m_pending);
      tests_run++;
      if (bus.wr_ready !== exp_rdy) begin
        tests_failed++; $display("FAIL random_wr_ready cyc=%0d: got %b want %b", cyc, bus.wr_ready, exp_rdy);
      end
      cycle();
      tests_run++;
      if (obs() !== e_out || bus.swap_done !== m_done || bus.active_bank !== m_active[0]) begin
        tests_failed++;
        $display("FAIL random_out cyc=%0d: got %h/%b/%b want %h/%b/%b", cyc, obs(), bus.swap_done,
                 bus.active_bank, e_out, m_done, m_active[0]);
      end
    end
  endtask

  task automatic test_reset_midstream();
    idle();
    bus.swap_req = 1'b1;
    cycle();
    idle();
    bus.vsync = 1'b1;
    cycle();
    for (int i = 0; i < 3; i++) begin
      idle();
      bus.wr_valid = 1'b1; bus.wr_index = IW'($urandom); bus.wr_rgb = 12'($urandom);
      bus.pix_valid = 1'b1; bus.pix_index = IW'($urandom_range(1, 15)); bus.fade_level = 4'hF;
      bus.swap_req = (i == 2);
      cycle();
    end
    Reset = 1'b1;
    #1;
    tests_run++;
    if (obs() !== '0) begin tests_failed++; $display("FAIL midreset_outputs: got %h want 0", obs()); end
    tests_run++;
    if ({bus.active_bank, bus.swap_done, bus.wr_ready} !== 3'b000) begin
      tests_failed++; $display("FAIL midreset_ctrl: got %b want 000", {bus.active_bank, bus.swap_done, bus.wr_ready});
    end
    m_reset();
    idle();
    cycle();
    Reset = 1'b0;
    #1;
    bus.vsync = 1'b1;
    cycle();
    tests_run++;
    if ({bus.active_bank, bus.swap_done} !== 2'b00) begin
      tests_failed++; $display("FAIL pending_discarded: got %b want 00", {bus.active_bank, bus.swap_done});
    end
    idle();
    bus.pix_valid = 1'b1; bus.pix_index = 4'd3; bus.fade_level = 4'hF;
    cycle();
    idle();
    tests_run++;
    if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL midreset_latency_1: got %b want 0", bus.out_valid); end
    cycle();
    tests_run++;
    if (obs() !== 14'h2000) begin tests_failed++; $display("FAIL midreset_latency_2: got %h want 2000", obs()); end
    bus.swap_req = 1'b1;
    cycle();
    idle();
    bus.vsync = 1'b1;
    cycle();
    idle();
    bus.pix_valid = 1'b1; bus.pix_index = 4'd3; bus.fade_level = 4'hF;
    cycle();
    idle();
    cycle();
    tests_run++;
    if (obs() !== 14'h2000 || bus.active_bank !== 1'b1) begin
      tests_failed++; $display("FAIL writes_lost: got %h bank %b want 2000 bank 1", obs(), bus.active_bank);
    end
  endtask

  initial begin
    idle();
    m_reset();
    test_reset();
    test_lookup_pre_swap();
    test_swap();
    test_fade();
    test_write_stall();
    test_double_swap();
    test_random();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/palette_bank_ctrl.md
PALETTE_BANK_CTRL -- requirements
Module: palette_bank_ctrl

Interface
REQ-001 The block SHALL have parameter INDEX_W, default 4, meaning palette index width; depth = 2^INDEX_W entries per bank.
REQ-002 The block SHALL have parameter CH_W, default 4, meaning bits per colour channel; entry width = 3*CH_W, packed {R,G,B}.
REQ-003 The block SHALL have parameter TRANSP_IDX, default 0, meaning the index flagged as transparent.
REQ-004 The block SHALL have port Clk, input, 1 bit: single system clock, rising-edge.
REQ-005 The block SHALL have port Reset, input, 1 bit: asynchronous, active-high.
REQ-006 The block SHALL have port wr_valid, input, 1 bit: palette write request.
REQ-007 The block SHALL have port wr_ready, output, 1 bit: write accepted when wr_valid & wr_ready.
REQ-008 The block SHALL have port wr_index, input, INDEX_W bits: entry to write.
REQ-009 The block SHALL have port wr_rgb, input, 3*CH_W bits: {R,G,B} write data.
REQ-010 The block SHALL have port swap_req, input, 1 bit: one-cycle pulse that arms a bank swap.
REQ-011 The block SHALL have port vsync, input, 1 bit: one-cycle frame-boundary pulse.
REQ-012 The block SHALL have port swap_done, output, 1 bit: one-cycle pulse when a swap takes effect.
REQ-013 The block SHALL have port active_bank, output, 1 bit: bank currently used for lookup.
REQ-014 The block SHALL have port pix_valid, input, 1 bit: lookup request.
REQ-015 The block SHALL have port pix_index, input, INDEX_W bits: index to look up.
REQ-016 The block SHALL have port fade_level, input, CH_W bits: brightness scale, all-ones = full.
REQ-017 The block SHALL have port out_valid, output, 1 bit: lookup result valid.
REQ-018 The block SHALL have port out_transparent, output, 1 bit: result index equals TRANSP_IDX.
REQ-019 The block SHALL have ports red, green, blue, output, CH_W bits each: faded colour.

Function
REQ-020 The block SHALL hold two register banks of 2^INDEX_W entries; the bank not equal to active_bank is the shadow bank.
REQ-021 The block SHALL write wr_rgb into shadow[wr_index] on the rising edge where wr_valid & wr_ready; active bank is never writable.
REQ-022 The block SHALL drive wr_ready = ~Reset & ~(vsync & swap_pending), combinational; stalled writes are retained by the source, not dropped.
REQ-023 The block SHALL set swap_pending on swap_req; swap_req while already pending is absorbed (one swap only).
REQ-024 The block SHALL, on a cycle with vsync & swap_pending, toggle active_bank, clear swap_pending and assert swap_done for exactly the next cycle.
REQ-025 The block SHALL, on swap_req and vsync in the same cycle with nothing pending, only arm; the swap occurs on the following vsync.
REQ-026 The block SHALL NOT copy bank contents on swap; the new shadow holds the previous active palette.
REQ-027 The block SHALL implement a 2-stage lookup pipeline: stage 1 registers active[pix_index], the transparent flag and fade_level; stage 2 registers scaled channels; latency = 2 cycles, throughput 1 per cycle, no back-pressure.
REQ-028 The block SHALL read the bank that is active at the stage-1 sampling edge; a lookup sampled in the swap cycle uses the pre-swap bank.
REQ-029 The block SHALL compute each channel as (ch * (fade_level+1)) >> CH_W using 2*CH_W+1-bit intermediates; fade all-ones returns ch exactly, fade 0 returns 0 for all ch < 2^CH_W.
REQ-030 The block SHALL propagate pix_valid to out_valid with 2-cycle latency; when out_valid is 0, red/green/blue/out_transparent hold their previous values.
REQ-031 The block SHALL return the new value for a lookup of an entry written in the same cycle only after a swap; same-cycle write/lookup of one index never conflicts, since writes target the shadow bank.

Reset
REQ-032 The block SHALL, while Reset is high, asynchronously clear both banks to 0, active_bank=0, swap_pending=0, swap_done=0, out_valid=0, out_transparent=0, red/green/blue=0, wr_ready=0.
REQ-033 The block SHALL discard in-flight pipeline contents and any pending swap on Reset mid-operation; first valid output appears 2 cycles after the first pix_valid after release.

Verification
REQ-034 Bench SHALL check: after reset, write idx 3 = {A,8,6}, swap_req, vsync, then lookup idx 3 with fade F -> out_valid 2 cycles later, RGB = A,8,6, swap_done pulsed once, active_bank=1.
REQ-035 Bench SHALL check: lookup idx 3 before the swap -> RGB 0,0,0; lookup idx 0 -> out_transparent=1.
REQ-036 Bench SHALL check fade: entry {F,8,1} with fade 7 -> RGB 7,4,0; fade 0 -> 0,0,0.
REQ-037 Bench SHALL check: swap_pending with vsync and wr_valid in the same cycle -> wr_ready=0, write lands in the next cycle in the new shadow bank (old active).
REQ-038 Bench SHALL check: double swap_req then two vsyncs -> exactly one swap and one swap_done.
REQ-039 Bench SHALL check: Reset asserted mid-stream with pipeline full -> all outputs 0 immediately (asynchronously), active_bank=0, prior writes lost.
